// File: rtl/cube_scan_ctrl.sv
// cube_scan_ctrl: layer-multiplexed scan scheduler for the 8x8x8 LED cube.
// Optional macro CUBE_SCAN_BRIGHT_EN adds a Bright input for per-frame dimming.
module cube_scan_ctrl #(
  parameter int LAYERS  = 8,
  parameter int COLS    = 64,
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 256
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [LAYERS*COLS-1:0] Cells,
  input  logic                   Frame_valid,
`ifdef CUBE_SCAN_BRIGHT_EN
  input  logic [2:0]             Bright,
`endif
  output logic                   Frame_ack,
  output logic                   Frame_start,
  output logic                   Sr_data,
  output logic                   Sr_clk,
  output logic                   Sr_latch,
  output logic [LAYERS-1:0]      Layer
);

  localparam int MAXD = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int PW   = $clog2(MAXD + 1);
  localparam int BW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int IW   = $clog2(LAYERS * COLS);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  localparam logic [PW-1:0] DIV_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DW_END  = PW'(DWELL - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(COLS - 1);
  localparam logic [LW-1:0] LAY_TOP = LW'(LAYERS - 1);

  logic [1:0]             state_q;
  logic [LAYERS*COLS-1:0] buf_q;
  logic [LW-1:0]          lay_q;
  logic [BW-1:0]          bit_q;
  logic [PW-1:0]          cnt_q;
  logic                   hi_q;
  logic                   phase_end;
  logic                   lit_on;
  logic [IW-1:0]          idx;

  assign phase_end = (state_q == S_DWELL) ? (cnt_q == DW_END)
                                          : (cnt_q == DIV_END);
  assign idx = IW'(lay_q) * IW'(COLS) + IW'(bit_q);

`ifdef CUBE_SCAN_BRIGHT_EN
  logic [PW-1:0] lit_q;
  logic [PW-1:0] lit_calc;
  logic [31:0]   lit_raw;

  // Lit length for this frame's brightness, never below one cycle
  always_comb begin
    lit_raw  = ((32'(Bright) + 32'd1) * 32'(DWELL)) >> 3;
    lit_calc = (lit_raw == 32'd0) ? PW'(1) : PW'(lit_raw);
  end

  // Brightness is frozen at the frame boundary
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      lit_q <= '0;
    else if (state_q == S_LOAD)
      lit_q <= lit_calc;
  end

  assign lit_on = (cnt_q < lit_q);
`else
  assign lit_on = 1'b1;
`endif

  // Scan FSM: load frame, shift each layer, latch, then light it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_LOAD;
      buf_q   <= '0;
      lay_q   <= '0;
      bit_q   <= BIT_TOP;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (Frame_valid)
            buf_q <= Cells;
          lay_q   <= '0;
          bit_q   <= BIT_TOP;
          cnt_q   <= '0;
          hi_q    <= 1'b0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (phase_end) begin
            cnt_q <= '0;
            hi_q  <= ~hi_q;
            if (hi_q) begin
              if (bit_q == '0)
                state_q <= S_LATCH;
              else
                bit_q <= bit_q - 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_end) begin
            cnt_q   <= '0;
            state_q <= S_DWELL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (phase_end) begin
            cnt_q <= '0;
            if (lay_q == LAY_TOP) begin
              state_q <= S_LOAD;
            end else begin
              lay_q   <= lay_q + 1'b1;
              bit_q   <= BIT_TOP;
              state_q <= S_SHIFT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Output decode; LOAD strobes are masked while Reset is held
  always_comb begin
    Frame_start = ~Reset & (state_q == S_LOAD);
    Frame_ack   = Frame_start & Frame_valid;
    Sr_clk      = (state_q == S_SHIFT) & hi_q;
    Sr_data     = (state_q == S_SHIFT) & buf_q[idx];
    Sr_latch    = (state_q == S_LATCH);
    Layer       = '0;
    if (state_q == S_DWELL && lit_on)
      Layer = LAYERS'(1) << lay_q;
  end

endmodule
